// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the single-issue MIPS datapath.
// Owns the PC and IR, registers datapath controls at decode, and supports stall and halt.
module multicycle_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                halt_req,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         ir,
    output logic                write_data_select,
    output logic                alu_op,
    output logic                alu_select,
    output logic                reg_write,
    output logic                retire,
    output logic                illegal_op,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    state_t              r_state, w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_ir;
    logic                r_started;
    logic                r_wds, r_alu_op, r_alu_sel, r_legal;
    logic                w_fetch_done, w_rtype, w_itype;

    // r_started keeps imem_req low until the first clock edge after reset release.
    assign w_fetch_done = (r_state == S_FETCH) && r_started && imem_ack;
    assign w_rtype      = (r_ir[31:26] == 6'b000000);
    assign w_itype      = (r_ir[31:26] == 6'b111111);

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = w_fetch_done ? S_DECODE : S_FETCH;
            S_DECODE:    w_next = stall ? S_DECODE : S_EXECUTE;
            S_EXECUTE:   w_next = stall ? S_EXECUTE : S_WRITEBACK;
            S_WRITEBACK: w_next = halt_req ? S_HALT : S_FETCH;
            S_HALT:      w_next = halt_req ? S_HALT : S_FETCH;
            default:     w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_started <= 1'b0;
            r_wds     <= 1'b0;
            r_alu_op  <= 1'b0;
            r_alu_sel <= 1'b0;
            r_legal   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_started <= 1'b1;
            if (w_fetch_done)
                r_ir <= imem_rdata;
            // Controls latch on the edge leaving DECODE so they are stable through WRITEBACK.
            if (r_state == S_DECODE && !stall) begin
                r_wds     <= w_rtype;
                r_alu_op  <= w_rtype;
                r_alu_sel <= w_itype;
                r_legal   <= w_rtype | w_itype;
            end
            if (r_state == S_WRITEBACK) begin
                r_pc      <= r_pc + PC_WIDTH'(4);
                r_wds     <= 1'b0;
                r_alu_op  <= 1'b0;
                r_alu_sel <= 1'b0;
            end
        end
    end

    assign imem_req          = (r_state == S_FETCH) && r_started;
    assign imem_addr         = r_pc;
    assign pc                = r_pc;
    assign ir                = r_ir;
    assign write_data_select = r_wds;
    assign alu_op            = r_alu_op;
    assign alu_select        = r_alu_sel;
    assign reg_write         = (r_state == S_WRITEBACK) && r_legal;
    assign retire            = (r_state == S_WRITEBACK);
    assign illegal_op        = (r_state == S_WRITEBACK) && !r_legal;
    assign halted            = (r_state == S_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: fetch latency, decode, illegal op, stall, halt,
// PC wrap (second instance at RESET_PC=0xFFFFFFFC) and reset during a fetch.
module tb_multicycle_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack, stall, halt_req;
    logic [31:0] imem_rdata;

    logic        imem_req, wds, alu_op, alu_select, reg_write, retire, illegal_op, halted;
    logic [31:0] imem_addr, pc, ir;
    logic        imem_req2, wds2, alu_op2, alu_select2, reg_write2, retire2, illegal_op2, halted2;
    logic [31:0] imem_addr2, pc2, ir2;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;

    always #5 clk = ~clk;

    multicycle_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .halt_req(halt_req),
        .pc(pc), .ir(ir), .write_data_select(wds), .alu_op(alu_op), .alu_select(alu_select),
        .reg_write(reg_write), .retire(retire), .illegal_op(illegal_op), .halted(halted));

    multicycle_sequencer #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .halt_req(halt_req),
        .pc(pc2), .ir(ir2), .write_data_select(wds2), .alu_op(alu_op2), .alu_select(alu_select2),
        .reg_write(reg_write2), .retire(retire2), .illegal_op(illegal_op2), .halted(halted2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {imem_req, wds, alu_op, alu_select, reg_write, retire, illegal_op, halted}
    function automatic logic [7:0] outs();
        return {imem_req, wds, alu_op, alu_select, reg_write, retire, illegal_op, halted};
    endfunction

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0; halt_req = 1'b0;
        step(); step();
        chk("reset_outs", {24'd0, outs()}, 32'h0000_0000);
        chk("reset_pc", pc, 32'h0);
        chk("reset_ir", ir, 32'h0);
        chk("reset_pc2", pc2, 32'hFFFF_FFFC);

        // Release: imem_req only after the first edge with rst_n high.
        rst_n = 1'b1;
        #1;
        chk("req_before_edge", {31'd0, imem_req}, 32'd0);
        step();
        chk("req_after_edge", {31'd0, imem_req}, 32'd1);
        chk("addr_i1", imem_addr, 32'h0);

        // Instr 1: R-type, zero-wait.
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
        step(); imem_ack = 1'b0;                               // cycle 2 DECODE
        chk("i1_dec_outs", {24'd0, outs()}, 32'h00);
        step();                                                // cycle 3 EXECUTE
        chk("i1_exe_outs", {24'd0, outs()}, 32'h60);
        step();                                                // cycle 4 WRITEBACK
        chk("i1_wb_outs", {24'd0, outs()}, 32'h6C);
        chk("i1_wb_pc", pc, 32'h0);
        step();                                                // FETCH
        chk("i1_after_outs", {24'd0, outs()}, 32'h80);
        chk("i1_pc", pc, 32'h4);
        chk("wrap_pc2", pc2, 32'h0);

        // Instr 2: I-type, ack after 3 wait cycles -> 7 cycles total.
        chk("i2_addr_c1", imem_addr, 32'h4);
        step(); chk("i2_addr_c2", imem_addr, 32'h4);
        step(); chk("i2_addr_c3", imem_addr, 32'h4);
        step(); chk("i2_addr_c4", {imem_addr[30:0], imem_req}, {31'h4, 1'b1});
        imem_ack = 1'b1; imem_rdata = 32'hFC00_0000;
        step(); imem_ack = 1'b0;                               // cycle 5 DECODE
        chk("i2_ir", ir, 32'hFC00_0000);
        step();                                                // cycle 6 EXECUTE
        chk("i2_exe_outs", {24'd0, outs()}, 32'h10);
        step();                                                // cycle 7 WRITEBACK
        chk("i2_wb_outs", {24'd0, outs()}, 32'h1C);
        step();
        chk("i2_pc", pc, 32'h8);

        // Instr 3: illegal opcode 000010.
        imem_ack = 1'b1; imem_rdata = 32'h0800_0000;
        step(); imem_ack = 1'b0;
        step();
        chk("i3_exe_outs", {24'd0, outs()}, 32'h00);
        step();
        chk("i3_wb_outs", {24'd0, outs()}, 32'h06);
        step();
        chk("i3_after_outs", {24'd0, outs()}, 32'h80);
        chk("i3_pc", pc, 32'hC);

        // Instr 4: stall 2 cycles in DECODE, 1 in EXECUTE, halt requested in EXECUTE.
        imem_ack = 1'b1; imem_rdata = 32'h0000_1234;
        step(); imem_ack = 1'b0; stall = 1'b1;                 // DECODE
        step(); chk("i4_dstall1", {24'd0, outs()}, 32'h00);
        step(); chk("i4_dstall2", {24'd0, outs()}, 32'h00);
        stall = 1'b0;
        step();                                                // EXECUTE
        chk("i4_exe_outs", {24'd0, outs()}, 32'h60);
        stall = 1'b1; halt_req = 1'b1;
        step(); chk("i4_estall", {24'd0, outs()}, 32'h60);
        stall = 1'b0;
        step();                                                // WRITEBACK
        chk("i4_wb_outs", {24'd0, outs()}, 32'h6C);
        step();                                                // HALT
        chk("i4_halt_outs", {24'd0, outs()}, 32'h01);
        chk("i4_pc", pc, 32'h10);
        step();
        chk("i4_halt_hold", {24'd0, outs()}, 32'h01);
        halt_req = 1'b0;
        step();
        chk("resume_outs", {24'd0, outs()}, 32'h80);
        chk("resume_addr", imem_addr, 32'h10);
        chk("pc2_after4", pc2, 32'hC);
        chk("i4_ir", ir, 32'h0000_1234);

        // Reset asserted mid-FETCH while an ack is presented across the edge.
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
        #2 rst_n = 1'b0;
        #1 chk("rst_req_async", {31'd0, imem_req}, 32'd0);
        step();
        rst_n = 1'b1; imem_ack = 1'b0;
        chk("rst_ir", ir, 32'h0);
        chk("rst_pc", pc, 32'h0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            pulses += int'(reg_write) + int'(retire);
        end
        chk("rst_no_pulses", pulses, 32'd0);
        chk("rst_refetch", {imem_addr[30:0], imem_req}, {31'h0, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle instruction sequencer for the single-issue MIPS datapath. It fetches a 32-bit instruction over a req/ack instruction-memory port and decodes the opcode (bits 31:26). It then steps FETCH → DECODE → EXECUTE → WRITEBACK, driving the datapath controls `write_data_select`, `alu_op`, `alu_select` and a single-cycle `reg_write` strobe. It owns the PC and supports external stall and halt.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of the PC and `imem_addr`.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  PC_WIDTH  fetch address; equals `pc`.
- `imem_ack`  in  1  fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction.
- `stall`  in  1  holds the sequencer in DECODE or EXECUTE.
- `halt_req`  in  1  requests a halt at the next instruction boundary.
- `pc`  out  PC_WIDTH  current instruction address.
- `ir`  out  32  instruction register.
- `write_data_select`  out  1  1 = ALU result to register file.
- `alu_op`  out  1  1 = R-type function decode.
- `alu_select`  out  1  1 = immediate operand.
- `reg_write`  out  1  register-file write strobe.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `illegal_op`  out  1  one-cycle pulse when an unsupported opcode completes.
- `halted`  out  1  sequencer is in HALT.

## Operation
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALT. There is no other state. Any unreachable encoding goes to FETCH.
- FETCH:
  - `imem_req`=1; `imem_addr`=`pc`, held stable while in FETCH.
  - On an edge with `imem_ack`=1, `ir` ← `imem_rdata` and the next state is DECODE.
  - Without ack, the sequencer stays in FETCH with no timeout.
- `imem_ack` is ignored outside FETCH.
- DECODE: controls are registered from `ir[31:26]`.
  - 000000: `alu_op`=1, `write_data_select`=1, `alu_select`=0, legal.
  - 111111: `alu_op`=0, `write_data_select`=0, `alu_select`=1, legal.
  - Other opcodes: all three controls = 0, illegal.
  - Next state is EXECUTE unless `stall`=1, in which case it stays in DECODE.
- EXECUTE: controls are held. Next state is WRITEBACK unless `stall`=1, in which case it stays in EXECUTE.
- WRITEBACK:
  - `reg_write`=1 only if the instruction is legal. `retire`=1. `illegal_op`=1 if the instruction is illegal.
  - `pc` ← `pc`+4, modulo 2^PC_WIDTH (wraps silently).
  - Next state is HALT if `halt_req`=1, otherwise FETCH. `stall` is ignored in WRITEBACK.
- HALT: `halted`=1 and `imem_req`=0. The sequencer goes to FETCH on the first edge with `halt_req`=0.
- `halt_req` in any state other than WRITEBACK takes no effect until the current instruction reaches WRITEBACK.
- Controls return to 0 in FETCH and HALT.

## Timing
- Reset (asynchronous, immediate on `rst_n`=0):
  - state=FETCH, `pc`=RESET_PC, `ir`=0.
  - Every output is 0: `imem_req`, all controls, `reg_write`, `retire`, `illegal_op`, `halted`.
- After reset release, `imem_req` rises in the first cycle following the first rising edge of `clk` with `rst_n`=1.
- Reset mid-fetch: `imem_req` drops asynchronously and any in-flight ack is discarded. Reset in WRITEBACK suppresses the PC increment.
- Zero-wait memory (ack in the first FETCH cycle) gives 4 cycles per instruction. Each cycle of ack delay adds 1 cycle, and each cycle of `stall` in DECODE or EXECUTE adds 1 cycle.
- Controls are valid from the cycle after the DECODE→EXECUTE edge through WRITEBACK. They are stable for at least 2 cycles before and including the `reg_write` cycle.
- `reg_write`, `retire` and `illegal_op` are each high for exactly one cycle per instruction.
- `halted` rises in the cycle after the WRITEBACK edge.

## Test plan
- Reset, then zero-wait ack, `imem_rdata`=0x00000000 → `imem_req` high with `imem_addr`=0. `reg_write` pulses in cycle 4 with `alu_op`=1, `write_data_select`=1, `alu_select`=0. Then `pc`=4.
- `imem_rdata`=0xFC000000 (opcode 111111), ack delayed 3 cycles → `imem_addr` stable for 4 cycles. `reg_write` with `alu_select`=1, `alu_op`=0. Instruction takes 7 cycles.
- Opcode 000010 → `reg_write` stays 0 and `illegal_op`/`retire` pulse once. `pc` still advances by 4.
- `stall` held 2 cycles in DECODE and 1 cycle in EXECUTE → WRITEBACK is delayed 3 cycles and `reg_write` stays a single pulse. `halt_req` asserted in EXECUTE → `halted`=1 after WRITEBACK and `imem_req`=0. Releasing `halt_req` resumes FETCH at `pc`+4.
- `RESET_PC`=0xFFFFFFFC → after one retire `pc`=0x00000000.
- `rst_n` pulsed low mid-FETCH with ack arriving the same cycle → `ir`=0, `pc`=RESET_PC, and no `reg_write` or `retire` pulse.
